// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage controller: FSM state encoding and
// the default sequential PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Single-entry holding register for a branch/jump redirect that arrives while
// instruction memory is stalled. A new set overwrites the held target.
module fetch_redirect_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic              clr,
    input  logic [ADDR_W-1:0] target,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_target
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (set) begin
            valid_d  = 1'b1;
            target_d = target;
        end else if (clr) begin
            valid_d  = 1'b0;
        end
    end

    // NOTE: the target is data-only and is read solely while valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        target_q <= target_d;
    end

    assign pend_valid  = valid_q;
    assign pend_target = target_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: chooses the next PC, drives the PC write enable and
// the IF/ID and ID/EX hazard controls, buffering redirects during imem waits.
module fetch_sequencer #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned PC_INC      = fetch_pkg::PC_INC,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic              ImemReady,
    input  logic              LoadUseStall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    output logic [ADDR_W-1:0] NextPC,
    output logic              NotStall,
    output logic              IFIDWrite,
    output logic              IFIDFlush,
    output logic              IDEXFlush,
    output logic [31:0]       StallCount
);

    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] INC       = ADDR_W'(PC_INC);
    localparam logic [3:0]        BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] seq_pc;
    logic              pend_valid, pend_set, pend_clr;
    logic [ADDR_W-1:0] pend_target;

    // Jump resolves in the same stage as branches and takes precedence.
    assign redirect        = Jump | BranchTaken;
    assign redirect_target = Jump ? JumpTarget : BranchTarget;
    assign seq_pc          = PC + INC;

    fetch_redirect_buf #(
        .ADDR_W(ADDR_W)
    ) u_redirect_buf (
        .clk        (Clk),
        .rst        (Reset),
        .set        (pend_set),
        .clr        (pend_clr),
        .target     (redirect_target),
        .pend_valid (pend_valid),
        .pend_target(pend_target)
    );

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        NextPC     = PC;
        NotStall   = 1'b0;
        IFIDWrite  = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;

        unique case (state_q)
            BOOT: begin
                NextPC    = '0;
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
                if (boot_cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - 4'd1;
                end
            end
            RUN: begin
                if (redirect && ImemReady) begin
                    NextPC    = redirect_target;
                    NotStall  = 1'b1;
                    IFIDWrite = 1'b1;
                    IFIDFlush = 1'b1;
                end else if (!ImemReady) begin
                    IFIDFlush = 1'b1;
                    pend_set  = redirect;
                    state_d   = WAIT;
                end else if (LoadUseStall) begin
                    IDEXFlush = 1'b1;
                end else begin
                    NextPC    = seq_pc;
                    NotStall  = 1'b1;
                    IFIDWrite = 1'b1;
                end
            end
            WAIT: begin
                IFIDFlush = 1'b1;
                if (ImemReady) begin
                    NotStall = 1'b1;
                    pend_clr = 1'b1;
                    state_d  = RUN;
                    // A redirect arriving on the ready cycle is newer than anything buffered.
                    if (redirect) begin
                        NextPC = redirect_target;
                    end else if (pend_valid) begin
                        NextPC = pend_target;
                    end else begin
                        NextPC    = seq_pc;
                        IFIDWrite = 1'b1;
                        IFIDFlush = 1'b0;
                    end
                end else begin
                    pend_set = redirect;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (state_q != BOOT && !NotStall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= BOOT;
            boot_cnt_q  <= BOOT_INIT;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked against a rule-level model of the fetch controller.
module tb_fetch_sequencer;

    localparam int BOOT_CYCLES = 2;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic        ImemReady;
    logic        LoadUseStall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] NextPC;
    logic        NotStall;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXFlush;
    logic [31:0] StallCount;

    fetch_sequencer #(
        .ADDR_W     (32),
        .PC_INC     (4),
        .BOOT_CYCLES(BOOT_CYCLES)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PC          (PC),
        .ImemReady   (ImemReady),
        .LoadUseStall(LoadUseStall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .NextPC      (NextPC),
        .NotStall    (NotStall),
        .IFIDWrite   (IFIDWrite),
        .IFIDFlush   (IFIDFlush),
        .IDEXFlush   (IDEXFlush),
        .StallCount  (StallCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: cycles of boot left, whether fetch is waiting on imem,
    // redirects buffered during the wait (newest at the back), stall tally.
    int          boot_left;
    bit          in_wait;
    logic [31:0] pend[$];
    logic [31:0] m_stalls;
    logic [31:0] pc;

    logic [31:0] obs_npc, obs_sc;
    logic        obs_ns, obs_w, obs_ff, obs_xf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string name);
        logic [31:0] e_npc;
        logic        e_ns, e_w, e_ff, e_xf;
        logic        redir;
        logic [31:0] tgt;
        PC = pc;
        @(negedge Clk);
        redir = Jump | BranchTaken;
        tgt   = Jump ? JumpTarget : BranchTarget;
        e_npc = pc;
        e_ns  = 1'b0;
        e_w   = 1'b0;
        e_ff  = 1'b0;
        e_xf  = 1'b0;
        if (boot_left > 0) begin
            e_npc = 32'd0;
            e_ff  = 1'b1;
            e_xf  = 1'b1;
        end else if (!in_wait) begin
            if (redir && ImemReady) begin
                e_npc = tgt; e_ns = 1'b1; e_w = 1'b1; e_ff = 1'b1;
            end else if (!ImemReady) begin
                e_ff = 1'b1;
            end else if (LoadUseStall) begin
                e_xf = 1'b1;
            end else begin
                e_npc = pc + 32'd4; e_ns = 1'b1; e_w = 1'b1;
            end
        end else begin
            e_ff = 1'b1;
            if (ImemReady) begin
                e_ns = 1'b1;
                if (redir) e_npc = tgt;
                else if (pend.size() != 0) e_npc = pend[$];
                else begin
                    e_npc = pc + 32'd4; e_w = 1'b1; e_ff = 1'b0;
                end
            end
        end

        obs_npc = NextPC;
        obs_ns  = NotStall;
        obs_w   = IFIDWrite;
        obs_ff  = IFIDFlush;
        obs_xf  = IDEXFlush;
        obs_sc  = StallCount;
        check({name, "_nextpc"},   obs_npc,        e_npc);
        check({name, "_notstall"}, 32'(obs_ns),    32'(e_ns));
        check({name, "_ifidwr"},   32'(obs_w),     32'(e_w));
        check({name, "_ifidfl"},   32'(obs_ff),    32'(e_ff));
        check({name, "_idexfl"},   32'(obs_xf),    32'(e_xf));
        check({name, "_stalls"},   obs_sc,         m_stalls);

        if (Reset) begin
            boot_left = BOOT_CYCLES;
            in_wait   = 1'b0;
            pend.delete();
            m_stalls  = 32'd0;
            pc        = 32'd0;
        end else begin
            if (boot_left > 0) begin
                boot_left--;
            end else begin
                if (!e_ns && m_stalls != 32'hFFFF_FFFF) m_stalls++;
                if (!in_wait) begin
                    if (!ImemReady) begin
                        in_wait = 1'b1;
                        if (redir) pend.push_back(tgt);
                    end
                end else if (ImemReady) begin
                    in_wait = 1'b0;
                    pend.delete();
                end else if (redir) begin
                    pend.push_back(tgt);
                end
            end
            if (e_ns) pc = e_npc;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Reset        = 1'b0;
        ImemReady    = 1'b1;
        LoadUseStall = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'd0;
        Jump         = 1'b0;
        JumpTarget   = 32'd0;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        pc    = 32'd0;
        PC    = 32'd0;
        @(posedge Clk);
        #1;
        boot_left = BOOT_CYCLES;
        in_wait   = 1'b0;
        pend.delete();
        m_stalls  = 32'd0;
        Reset     = 1'b0;

        // Boot hold then sequential fetch 0 -> 4 -> 8.
        step("t1_boot0");
        check("t1_boot0_pc0", obs_npc, 32'd0);
        step("t1_boot1");
        step("t1_run0");
        check("t1_run0_pc4", obs_npc, 32'd4);
        step("t1_run1");
        check("t1_run1_pc8", obs_npc, 32'd8);

        // Load-use stall holds IF/ID and bubbles ID/EX.
        pc = 32'h10;
        LoadUseStall = 1'b1;
        step("t2_lus");
        check("t2_lus_ns",   32'(obs_ns), 32'd0);
        check("t2_lus_idex", 32'(obs_xf), 32'd1);
        LoadUseStall = 1'b0;
        step("t2_resume");
        check("t2_resume_pc", obs_npc, 32'h14);

        // Branch overrides a simultaneous load-use stall.
        pc = 32'h20;
        BranchTaken = 1'b1; BranchTarget = 32'h100; LoadUseStall = 1'b1;
        step("t3_br");
        check("t3_br_pc",    obs_npc,         32'h100);
        check("t3_br_flush", 32'(obs_ff),     32'd1);
        idle_inputs();

        // Redirects during an imem wait: last one wins.
        pc = 32'h30;
        ImemReady = 1'b0; Jump = 1'b1; JumpTarget = 32'h40;
        step("t4_w1");
        Jump = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h80;
        step("t4_w2");
        BranchTaken = 1'b0;
        step("t4_w3");
        ImemReady = 1'b1;
        step("t4_ready");
        check("t4_ready_pc", obs_npc, 32'h80);
        // one earlier load-use stall plus three wait cycles
        check("t4_stalls",   obs_sc,  32'd4);
        ImemReady = 1'b0;
        step("t4_w4");
        ImemReady = 1'b1;
        step("t4_nopend");
        check("t4_nopend_pc", obs_npc, 32'h84);

        // PC wrap-around.
        pc = 32'hFFFF_FFFC;
        step("t5_wrap");
        check("t5_wrap_pc", obs_npc, 32'd0);

        // Reset while a redirect is pending in WAIT.
        ImemReady = 1'b0; Jump = 1'b1; JumpTarget = 32'h200;
        step("t6_pend");
        Jump = 1'b0; Reset = 1'b1;
        step("t6_rst");
        Reset = 1'b0; ImemReady = 1'b1;
        step("t6_boot0");
        check("t6_boot0_sc", obs_sc,  32'd0);
        check("t6_boot0_pc", obs_npc, 32'd0);
        step("t6_boot1");
        ImemReady = 1'b0;
        step("t6_wait");
        ImemReady = 1'b1;
        step("t6_nostale");
        check("t6_nostale_pc", obs_npc, 32'd4);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            Reset        = ($urandom_range(0, 99) < 2);
            ImemReady    = ($urandom_range(0, 3) != 0);
            LoadUseStall = ($urandom_range(0, 4) == 0);
            Jump         = ($urandom_range(0, 9) == 0);
            BranchTaken  = ($urandom_range(0, 7) == 0);
            JumpTarget   = $urandom() & 32'hFFFF_FFFC;
            BranchTarget = $urandom() & 32'hFFFF_FFFC;
            step("rnd");
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
